// File: rtl/bht_update_ctrl_pkg.sv
// Shared constants and state encoding for the BHT update controller.
package bht_update_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned ENTRIES_DEF = 8;
    localparam int unsigned IDX_W_DEF   = 3;
    localparam int unsigned DEPTH_DEF   = 4;

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Fall-through distance for a not-taken branch.
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with full/empty flags and a synchronous clear.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage array; no reset needed since contents are only read when valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Branch-history-table update controller: init walk, update queue, mispredict redirect.
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush_req,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_addr,
    output logic              bht_we,
    output logic [ADDR_W-1:0] bht_pc,
    output logic [ADDR_W-1:0] bht_target,
    output logic              bht_taken,
    output logic              bht_clr,
    output logic [IDX_W-1:0]  bht_clr_idx,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              init_busy,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int unsigned FIFO_W = 2 * ADDR_W + 1;

    state_e              state_q;
    logic [IDX_W-1:0]    walk_q;
    logic                redirect_q;
    logic [ADDR_W-1:0]   redirect_addr_q;
    logic [CNT_W-1:0]    mispred_cnt_q;

    logic                in_init;
    logic                in_run;
    logic                accept;
    logic                mispredict;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                fifo_clr;
    logic [FIFO_W-1:0]   fifo_rdata;
    logic [ADDR_W-1:0]   fix_addr;

    assign in_init    = (state_q == ST_INIT);
    assign in_run     = (state_q == ST_RUN);
    assign upd_ready  = in_run && !fifo_full && !flush_req;
    assign accept     = upd_valid && upd_ready && en;
    assign mispredict = (upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_addr));
    assign fix_addr   = upd_taken ? upd_target : (upd_pc + ADDR_W'(PC_STEP));
    assign fifo_pop   = in_run && en && !fifo_empty;
    assign fifo_clr   = en && flush_req;

    // Pending table writes, drained one per enabled RUN cycle.
    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifo_clr),
        .push_i  (accept),
        .pop_i   (fifo_pop),
        .wdata_i ({upd_pc, upd_target, upd_taken}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bht_we      = fifo_pop;
    assign bht_pc      = fifo_rdata[2*ADDR_W:ADDR_W+1];
    assign bht_target  = fifo_rdata[ADDR_W:1];
    assign bht_taken   = fifo_rdata[0];
    assign bht_clr     = in_init && en;
    assign bht_clr_idx = walk_q;
    assign init_busy   = in_init;

    assign redirect      = redirect_q && en;
    assign redirect_addr = redirect_addr_q;
    assign mispred_cnt   = mispred_cnt_q;

    // Init/run FSM; flush restarts the invalidation walk from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            walk_q  <= '0;
        end else if (en) begin
            if (flush_req) begin
                state_q <= ST_INIT;
                walk_q  <= '0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (walk_q == IDX_W'(ENTRIES - 1)) begin
                            state_q <= ST_RUN;
                            walk_q  <= '0;
                        end else begin
                            walk_q <= walk_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Mispredict pulse, corrected PC and saturating counter (flush leaves the count alone).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            redirect_q <= accept && mispredict;
            if (accept && mispredict) begin
                redirect_addr_q <= fix_addr;
                if (mispred_cnt_q != CNT_MAX) begin
                    mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: cycle model on negedge, expected writes queued on acceptance.
module tb_bht_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush_req;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_addr;
    logic        bht_we;
    logic [31:0] bht_pc;
    logic [31:0] bht_target;
    logic        bht_taken;
    logic        bht_clr;
    logic [2:0]  bht_clr_idx;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        init_busy;
    logic [15:0] mispred_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    ent_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    logic        m_init;
    int          m_walk;
    int          m_cnt;
    logic        m_red;
    logic [31:0] m_red_addr;
    logic [15:0] m_mcnt;
    logic        m_acc;

    bht_update_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush_req      (flush_req),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_addr  (upd_pred_addr),
        .bht_we         (bht_we),
        .bht_pc         (bht_pc),
        .bht_target     (bht_target),
        .bht_taken      (bht_taken),
        .bht_clr        (bht_clr),
        .bht_clr_idx    (bht_clr_idx),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .init_busy      (init_busy),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
            end
        end
    endtask

    // Model-based checker and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        ent_t e;
        logic exp_ready;
        logic exp_we;
        logic acc;
        logic mis;
        if (!rst_n) begin
            m_init = 1'b1; m_walk = 0; m_cnt = 0; m_red = 1'b0;
            m_red_addr = 32'h0; m_mcnt = 16'h0; m_acc = 1'b0;
            exp_q.delete();
            check_eq("rst_busy",     64'(init_busy),     64'(1));
            check_eq("rst_we",       64'(bht_we),        64'(0));
            check_eq("rst_redirect", 64'(redirect),      64'(0));
            check_eq("rst_raddr",    64'(redirect_addr), 64'(0));
            check_eq("rst_mcnt",     64'(mispred_cnt),   64'(0));
        end else begin
            exp_ready = !m_init && (m_cnt < 4) && !flush_req;
            exp_we    = !m_init && en && (m_cnt != 0);
            check_eq("init_busy", 64'(init_busy), 64'(m_init));
            check_eq("bht_clr",   64'(bht_clr),   64'(m_init && en));
            if (m_init && en) begin
                check_eq("bht_clr_idx", 64'(bht_clr_idx), 64'(m_walk));
            end
            check_eq("upd_ready", 64'(upd_ready), 64'(exp_ready));
            check_eq("bht_we",    64'(bht_we),    64'(exp_we));
            check_eq("we_clr_excl", 64'(bht_we && bht_clr), 64'(0));
            if (exp_we && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("bht_pc",     64'(bht_pc),     64'(e.pc));
                check_eq("bht_target", 64'(bht_target), 64'(e.tgt));
                check_eq("bht_taken",  64'(bht_taken),  64'(e.tk));
            end
            check_eq("redirect", 64'(redirect), 64'(m_red && en));
            if (m_red && en) begin
                check_eq("redirect_addr", 64'(redirect_addr), 64'(m_red_addr));
            end
            check_eq("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));

            // Advance the model to the next cycle.
            acc   = en && upd_valid && exp_ready;
            mis   = (upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_addr));
            m_acc = acc;
            m_red = acc && mis;
            if (acc && mis) begin
                m_red_addr = upd_taken ? upd_target : (upd_pc + 32'd4);
                if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
            end
            if (en) begin
                if (flush_req) begin
                    m_init = 1'b1; m_walk = 0; m_cnt = 0;
                    exp_q.delete();
                end else if (m_init) begin
                    if (m_walk == 7) begin
                        m_init = 1'b0; m_walk = 0;
                    end else begin
                        m_walk = m_walk + 1;
                    end
                end else begin
                    if (acc) exp_q.push_back('{pc: upd_pc, tgt: upd_target, tk: upd_taken});
                    m_cnt = m_cnt + (acc ? 1 : 0) - (exp_we ? 1 : 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_run();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (!m_init) done = 1'b1;
        end
        check_eq("walk_done", 64'(done), 64'(1));
    endtask

    // Offer one update and hold it until the model sees it accepted.
    task automatic offer(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic ptk, input logic [31:0] paddr, input logic toggle_en);
        logic done;
        done           = 1'b0;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_pred_taken = ptk;
        upd_pred_addr  = paddr;
        upd_valid      = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            step();
            if (m_acc) done = 1'b1;
            else if (toggle_en) en = ~en;
        end
        upd_valid = 1'b0;
        check_eq("offer_accepted", 64'(done), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; en = 1'b0; flush_req = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_pred_taken = 1'b0; upd_pred_addr = '0;
        idle(3);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_run();

        // First mispredict: taken while predicted not-taken.
        offer(32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(2);
        check_eq("mcnt_first", 64'(mispred_cnt), 64'(1));

        // Direction/target pattern mix, including fall-through wrap at the top of memory.
        offer(32'h300, 32'h400, 1'b1, 1'b1, 32'h400, 1'b0);
        offer(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 32'h10, 1'b0);
        offer(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 32'h10, 1'b0);
        offer(32'h500, 32'h600, 1'b1, 1'b1, 32'h700, 1'b0);
        idle(3);

        // Four updates with the pipeline enable toggling underneath.
        for (int i = 0; i < 4; i++) begin
            offer(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 1'(i % 2), 1'b0, 32'h0, 1'b1);
        end
        en = 1'b1;
        idle(4);

        // Flush with an entry still queued; the walk repeats and the counter is kept.
        offer(32'h40, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        wait_run();

        // Randomised traffic with occasional flushes and stalls.
        for (int i = 0; i < 400; i++) begin
            r              = $urandom;
            upd_pc         = (i % 37 == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
            upd_target     = $urandom & 32'hFFFF_FFFC;
            upd_taken      = 1'($urandom_range(0, 1));
            upd_pred_taken = 1'($urandom_range(0, 1));
            upd_pred_addr  = ($urandom_range(0, 2) != 0) ? upd_target : ($urandom & 32'hFFFF_FFFC);
            upd_valid      = 1'($urandom_range(0, 1));
            en             = ($urandom_range(0, 3) != 0);
            flush_req      = ($urandom_range(0, 24) == 0);
            step();
        end
        upd_valid = 1'b0; flush_req = 1'b0; en = 1'b1;
        wait_run();
        idle(2);

        // Reset in the middle of the walk.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        idle(3);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        wait_run();

        // Reset with a queued entry and a pending redirect.
        offer(32'h900, 32'hA00, 1'b1, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        wait_run();

        // Saturation: 65534 mispredicts to reach FFFE, then three more.
        upd_pc = 32'h2000; upd_target = 32'h3000; upd_taken = 1'b1;
        upd_pred_taken = 1'b0; upd_pred_addr = 32'h0;
        upd_valid = 1'b1;
        idle(65534);
        check_eq("mcnt_fffe", 64'(mispred_cnt), 64'(16'hFFFE));
        idle(3);
        upd_valid = 1'b0;
        idle(3);
        check_eq("mcnt_sat", 64'(mispred_cnt), 64'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
